uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the TX FIFO control state type.
// Holds FIFO depth default, byte width and serializer clock divider.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_BYTE_W     = 8;

  // System clock and serializer tick rate used to derive the divider.
  localparam int UART_CLK_HZ  = 50_000_000;
  localparam int UART_TICK_HZ = 1_000_000;
  localparam int UART_CLK_DIV = UART_CLK_HZ / UART_TICK_HZ;

  typedef enum logic [1:0] {
    EMPTY_S = 2'd0,
    FILL_S  = 2'd1,
    FULL_S  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART TX FIFO: one synchronous write port,
// one asynchronous read port. Ports: CLK, i_we, i_waddr, i_wdata,
// i_raddr, o_rdata. Contents are not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic                   CLK,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [UART_BYTE_W-1:0] i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output logic [UART_BYTE_W-1:0] o_rdata
);

  logic [UART_BYTE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding a UART serializer.
// Inputs: CLK, RST (async high), WR_DATA/WR_EN push, CLR_OVF,
// TX_IDLE (serializer ready). Outputs: TX_DATA/TX_DATA_READY head
// byte, FULL, EMPTY, COUNT, sticky OVERFLOW (a write was dropped).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [UART_BYTE_W-1:0] WR_DATA,
  input  logic                   WR_EN,
  input  logic                   CLR_OVF,
  input  logic                   TX_IDLE,
  output logic [UART_BYTE_W-1:0] TX_DATA,
  output logic                   TX_DATA_READY,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [AW:0]            COUNT,
  output logic                   OVERFLOW
);

  localparam logic [AW:0] LP_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LP_LAST = (AW+1)'(DEPTH - 1);

  fifo_state_t r_state;
  fifo_state_t w_state_nxt;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_ovf;

  logic w_push;
  logic w_pop;
  logic w_drop;

  assign EMPTY         = (r_state == EMPTY_S);
  assign FULL          = (r_state == FULL_S);
  assign TX_DATA_READY = ~EMPTY;
  assign COUNT         = r_count;
  assign OVERFLOW      = r_ovf;

  // A write while full is dropped even if a pop happens in the same
  // cycle: the slot freed by the pop is not reused until next cycle.
  assign w_push = WR_EN & ~FULL;
  assign w_pop  = TX_DATA_READY & TX_IDLE;
  assign w_drop = WR_EN & FULL;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK     (CLK),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (WR_DATA),
    .i_raddr (r_rd_ptr),
    .o_rdata (TX_DATA)
  );

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LP_ONE;
      2'b01:   w_count_nxt = r_count - LP_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY_S: begin
        if (w_push) begin
          w_state_nxt = FILL_S;
        end
      end
      FILL_S: begin
        if (w_push && !w_pop && r_count == LP_LAST) begin
          w_state_nxt = FULL_S;
        end else if (w_pop && !w_push && r_count == LP_ONE) begin
          w_state_nxt = EMPTY_S;
        end
      end
      FULL_S: begin
        if (w_pop) begin
          w_state_nxt = FILL_S;
        end
      end
      default: w_state_nxt = EMPTY_S;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= EMPTY_S;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      // A new drop wins over a simultaneous clear.
      r_ovf   <= w_drop | (r_ovf & ~CLR_OVF);
    end
  end

endmodule
